// File: rtl/riscv_trace_pkg.sv
// Shared types for the post-trigger trace buffer: FSM state encoding and
// the {PC, ALU result} entry that is captured once per cycle.
package riscv_trace_pkg;

    localparam int TRACE_XLEN = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } trace_state_t;

    typedef struct packed {
        logic [TRACE_XLEN-1:0] pc;
        logic [TRACE_XLEN-1:0] alu;
    } trace_entry_t;

endpackage

// File: rtl/trace_ram.sv
// DEPTH-entry trace storage: synchronous write, combinational read, no reset.
// Contents are only meaningful where the top level has written them.
module trace_ram
    import riscv_trace_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         we_i,
    input  logic [AW-1:0] waddr_i,
    input  trace_entry_t wdata_i,
    input  logic [AW-1:0] raddr_i,
    output trace_entry_t rdata_o
);

    trace_entry_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/riscv_trace_buffer.sv
// Arms on request, records one {PC, ALU} entry per cycle from the trigger PC
// until full, then drains oldest-first over a valid/ready port.
module riscv_trace_buffer
    import riscv_trace_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int XLEN  = TRACE_XLEN
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    arm,
    input  logic [XLEN-1:0]         trig_pc,
    input  logic [XLEN-1:0]         pc_in,
    input  logic [XLEN-1:0]         alu_in,
    output logic                    rd_valid,
    input  logic                    rd_ready,
    output logic [XLEN-1:0]         rd_pc,
    output logic [XLEN-1:0]         rd_alu,
    output logic [1:0]              state_o,
    output logic [$clog2(DEPTH):0]  count_o,
    output logic                    full_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    trace_state_t  state_q, state_d;
    logic [PW-1:0] wrPtr_q, wrPtr_d;
    logic [PW-1:0] rdPtr_q, rdPtr_d;
    logic [CW-1:0] count_q, count_d;
    logic          wrEn;
    trace_entry_t  wrEntry;
    trace_entry_t  rdEntry;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    assign rd_valid = (state_q == DONE) && (count_q != '0);

    // arm overrides everything, including a same-cycle trigger match or pop
    always_comb begin
        state_d = state_q;
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        wrEn    = 1'b0;
        if (arm) begin
            state_d = ARMED;
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
        end else begin
            unique case (state_q)
                IDLE: ;
                ARMED: begin
                    if (pc_in == trig_pc) begin
                        wrEn    = 1'b1;
                        wrPtr_d = wrPtr_q + PW'(1);
                        count_d = CW'(1);
                        state_d = CAPTURE;
                    end
                end
                CAPTURE: begin
                    wrEn    = 1'b1;
                    wrPtr_d = wrPtr_q + PW'(1);
                    count_d = count_q + CW'(1);
                    if (count_q == FULL_COUNT - CW'(1)) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    if (rd_valid && rd_ready) begin
                        rdPtr_d = rdPtr_q + PW'(1);
                        count_d = count_q - CW'(1);
                        if (count_q == CW'(1)) begin
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // entries are stored at TRACE_XLEN; XLEN is expected to match it
    assign wrEntry.pc  = TRACE_XLEN'(pc_in);
    assign wrEntry.alu = TRACE_XLEN'(alu_in);

    trace_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .we_i    (wrEn),
        .waddr_i (wrPtr_q),
        .wdata_i (wrEntry),
        .raddr_i (rdPtr_q),
        .rdata_o (rdEntry)
    );

    assign rd_pc   = rd_valid ? XLEN'(rdEntry.pc)  : '0;
    assign rd_alu  = rd_valid ? XLEN'(rdEntry.alu) : '0;
    assign state_o = state_q;
    assign count_o = count_q;
    assign full_o  = (count_q == FULL_COUNT);

endmodule

// File: tb/tb_riscv_trace_buffer.sv
// Self-checking bench for riscv_trace_buffer (DEPTH=4): fixed vector table,
// hand-written corner sequences and random traffic against a queue model.
module tb_riscv_trace_buffer;

    localparam int DEPTH = 4;
    localparam int XLEN  = 32;
    localparam int CW    = $clog2(DEPTH) + 1;

    localparam int S_IDLE    = 0;
    localparam int S_ARMED   = 1;
    localparam int S_CAPTURE = 2;
    localparam int S_DONE    = 3;

    logic            clk = 1'b0;
    logic            reset;
    logic            arm;
    logic [XLEN-1:0] trig_pc;
    logic [XLEN-1:0] pc_in;
    logic [XLEN-1:0] alu_in;
    logic            rd_valid;
    logic            rd_ready;
    logic [XLEN-1:0] rd_pc;
    logic [XLEN-1:0] rd_alu;
    logic [1:0]      state_o;
    logic [CW-1:0]   count_o;
    logic            full_o;

    int assertCount = 0;
    int failCount   = 0;

    int          mState;
    logic [63:0] mq[$];

    typedef struct {
        logic        a;
        logic [31:0] t;
        logic [31:0] p;
        logic [31:0] al;
        logic        r;
        logic [1:0]  eState;
        int          eCount;
        logic        eFull;
        logic        eValid;
        logic [31:0] ePc;
        logic [31:0] eAlu;
    } vec_t;

    vec_t vecs[11];

    always #5 clk = ~clk;

    riscv_trace_buffer #(
        .DEPTH (DEPTH),
        .XLEN  (XLEN)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .arm      (arm),
        .trig_pc  (trig_pc),
        .pc_in    (pc_in),
        .alu_in   (alu_in),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .rd_pc    (rd_pc),
        .rd_alu   (rd_alu),
        .state_o  (state_o),
        .count_o  (count_o),
        .full_o   (full_o)
    );

    // Records an actual-vs-required comparison and reports any difference.
    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic modelReset();
        mq.delete();
        mState = S_IDLE;
    endtask

    // Transaction-level behaviour: a queue that fills from the trigger PC and drains from the front.
    task automatic modelStep(input logic a, input logic [31:0] t, input logic [31:0] p,
                             input logic [31:0] al, input logic r);
        logic [63:0] tmp;
        if (a) begin
            mq.delete();
            mState = S_ARMED;
        end else begin
            case (mState)
                S_ARMED: begin
                    if (p == t) begin
                        mq.push_back({p, al});
                        mState = (mq.size() == DEPTH) ? S_DONE : S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    mq.push_back({p, al});
                    if (mq.size() == DEPTH) mState = S_DONE;
                end
                S_DONE: begin
                    if (mq.size() > 0 && r) begin
                        tmp = mq.pop_front();
                        if (mq.size() == 0) mState = S_IDLE;
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic checkAll(input string tag);
        logic        mValid;
        logic [31:0] ePc;
        logic [31:0] eAlu;
        mValid = (mState == S_DONE) && (mq.size() > 0);
        ePc    = mValid ? mq[0][63:32] : 32'h0;
        eAlu   = mValid ? mq[0][31:0]  : 32'h0;
        checkOutput({tag, ".state"},    64'(state_o),  64'(mState));
        checkOutput({tag, ".count"},    64'(count_o),  64'(mq.size()));
        checkOutput({tag, ".full"},     64'(full_o),   64'(mq.size() == DEPTH));
        checkOutput({tag, ".rd_valid"}, 64'(rd_valid), 64'(mValid));
        checkOutput({tag, ".rd_pc"},    64'(rd_pc),    64'(ePc));
        checkOutput({tag, ".rd_alu"},   64'(rd_alu),   64'(eAlu));
    endtask

    // Drives one cycle of inputs, advances the model on the same edge, then checks.
    task automatic applyStimulus(input logic a, input logic [31:0] t, input logic [31:0] p,
                                 input logic [31:0] al, input logic r, input string tag);
        arm      = a;
        trig_pc  = t;
        pc_in    = p;
        alu_in   = al;
        rd_ready = r;
        @(posedge clk);
        modelStep(a, t, p, al, r);
        #1;
        checkAll(tag);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] popped[$];
        logic [31:0] expPc[6];
        logic        readySeq[6];
        logic [31:0] curTrig;
        int          popCount;

        vecs[0]  = '{1'b1, 32'h10, 32'h00, 32'h01, 1'b0, 2'd1, 0, 1'b0, 1'b0, 32'h00, 32'h00};
        vecs[1]  = '{1'b0, 32'h10, 32'h0C, 32'h0D, 1'b0, 2'd1, 0, 1'b0, 1'b0, 32'h00, 32'h00};
        vecs[2]  = '{1'b0, 32'h10, 32'h10, 32'h11, 1'b0, 2'd2, 1, 1'b0, 1'b0, 32'h00, 32'h00};
        vecs[3]  = '{1'b0, 32'h10, 32'h14, 32'h15, 1'b0, 2'd2, 2, 1'b0, 1'b0, 32'h00, 32'h00};
        vecs[4]  = '{1'b0, 32'h10, 32'h18, 32'h19, 1'b0, 2'd2, 3, 1'b0, 1'b0, 32'h00, 32'h00};
        vecs[5]  = '{1'b0, 32'h10, 32'h1C, 32'h1D, 1'b0, 2'd3, 4, 1'b1, 1'b1, 32'h10, 32'h11};
        vecs[6]  = '{1'b0, 32'h10, 32'h20, 32'h21, 1'b0, 2'd3, 4, 1'b1, 1'b1, 32'h10, 32'h11};
        vecs[7]  = '{1'b0, 32'h10, 32'h20, 32'h21, 1'b1, 2'd3, 3, 1'b0, 1'b1, 32'h14, 32'h15};
        vecs[8]  = '{1'b0, 32'h10, 32'h20, 32'h21, 1'b1, 2'd3, 2, 1'b0, 1'b1, 32'h18, 32'h19};
        vecs[9]  = '{1'b0, 32'h10, 32'h20, 32'h21, 1'b1, 2'd3, 1, 1'b0, 1'b1, 32'h1C, 32'h1D};
        vecs[10] = '{1'b0, 32'h10, 32'h20, 32'h21, 1'b1, 2'd0, 0, 1'b0, 1'b0, 32'h00, 32'h00};

        // Reset held low while the PC toggles.
        reset    = 1'b0;
        arm      = 1'b0;
        trig_pc  = 32'h0;
        pc_in    = 32'h0;
        alu_in   = 32'h0;
        rd_ready = 1'b0;
        modelReset();
        for (int i = 0; i < 4; i++) begin
            #5 pc_in = pc_in ^ 32'h4;
        end
        #1;
        checkOutput("reset.state",    64'(state_o),  64'd0);
        checkOutput("reset.count",    64'(count_o),  64'd0);
        checkOutput("reset.rd_valid", 64'(rd_valid), 64'd0);
        checkOutput("reset.rd_pc",    64'(rd_pc),    64'd0);
        checkAll("reset");
        @(negedge clk);
        reset = 1'b1;

        // Trigger, fill and drain against the fixed table.
        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].a, vecs[i].t, vecs[i].p, vecs[i].al, vecs[i].r, $sformatf("vec%0d", i));
            checkOutput($sformatf("vec%0d.tstate", i), 64'(state_o),  64'(vecs[i].eState));
            checkOutput($sformatf("vec%0d.tcount", i), 64'(count_o),  64'(vecs[i].eCount));
            checkOutput($sformatf("vec%0d.tfull", i),  64'(full_o),   64'(vecs[i].eFull));
            checkOutput($sformatf("vec%0d.tvalid", i), 64'(rd_valid), 64'(vecs[i].eValid));
            checkOutput($sformatf("vec%0d.tpc", i),    64'(rd_pc),    64'(vecs[i].ePc));
            checkOutput($sformatf("vec%0d.talu", i),   64'(rd_alu),   64'(vecs[i].eAlu));
        end

        // No trigger: PC never reaches the trigger address.
        applyStimulus(1'b1, 32'hFFC, 32'h0, 32'h1, 1'b0, "notrig.arm");
        for (int p = 0; p <= 32'h100; p += 4) begin
            applyStimulus(1'b0, 32'hFFC, 32'(p), 32'(p + 1), 1'b1, "notrig");
        end
        checkOutput("notrig.state", 64'(state_o), 64'd1);
        checkOutput("notrig.count", 64'(count_o), 64'd0);

        // Backpressure during drain.
        applyStimulus(1'b1, 32'h40, 32'h0, 32'h0, 1'b0, "bp.arm");
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, 32'h40, 32'h40 + 32'(4 * k), 32'h1000 + 32'(k), 1'b0, "bp.fill");
        end
        checkOutput("bp.done", 64'(state_o), 64'd3);
        readySeq = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        expPc    = '{32'h44, 32'h44, 32'h44, 32'h48, 32'h4C, 32'h0};
        popCount = 0;
        for (int j = 0; j < 6; j++) begin
            if (rd_valid && readySeq[j]) begin
                popped.push_back(rd_pc);
                popCount++;
            end
            applyStimulus(1'b0, 32'h40, 32'h0, 32'h0, readySeq[j], "bp");
            checkOutput($sformatf("bp.rd_pc%0d", j), 64'(rd_pc), 64'(expPc[j]));
        end
        checkOutput("bp.pops", 64'(popCount), 64'd4);
        for (int i = 0; i < popped.size(); i++) begin
            checkOutput($sformatf("bp.order%0d", i), 64'(popped[i]), 64'(32'h40 + 32'(4 * i)));
        end
        checkOutput("bp.idle", 64'(state_o), 64'd0);

        // Re-arm while popping with two entries left; same-cycle trigger is also dropped.
        applyStimulus(1'b1, 32'h80, 32'h0, 32'h0, 1'b0, "rearm.arm");
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, 32'h80, 32'h80 + 32'(4 * k), 32'h2000 + 32'(k), 1'b0, "rearm.fill");
        end
        applyStimulus(1'b0, 32'h80, 32'h0, 32'h0, 1'b1, "rearm.pop");
        applyStimulus(1'b0, 32'h80, 32'h0, 32'h0, 1'b1, "rearm.pop");
        checkOutput("rearm.count2", 64'(count_o), 64'd2);
        applyStimulus(1'b1, 32'h80, 32'h80, 32'h9, 1'b1, "rearm");
        checkOutput("rearm.state",    64'(state_o),  64'd1);
        checkOutput("rearm.count",    64'(count_o),  64'd0);
        checkOutput("rearm.rd_valid", 64'(rd_valid), 64'd0);
        applyStimulus(1'b0, 32'h80, 32'h80, 32'h5, 1'b0, "rearm.trig");
        checkOutput("rearm.trig_count", 64'(count_o), 64'd1);

        // Asynchronous reset between edges at count 2.
        applyStimulus(1'b0, 32'h80, 32'h84, 32'h6, 1'b0, "areset.fill");
        checkOutput("areset.count2", 64'(count_o), 64'd2);
        #2 reset = 1'b0;
        #1;
        checkOutput("areset.state", 64'(state_o), 64'd0);
        checkOutput("areset.count", 64'(count_o), 64'd0);
        modelReset();
        checkAll("areset");
        @(negedge clk);
        reset = 1'b1;

        // Random traffic with frequent trigger hits and occasional re-arm.
        curTrig = 32'h100;
        for (int n = 0; n < 600; n++) begin
            logic a;
            a = ($urandom_range(0, 24) == 0);
            if (a) curTrig = 32'h100 + 32'(4 * $urandom_range(0, 7));
            applyStimulus(a, curTrig, 32'h100 + 32'(4 * $urandom_range(0, 7)), $urandom,
                          1'($urandom_range(0, 1)), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/riscv_trace_buffer.md
# riscv_trace_buffer

Post-trigger execution trace capture attached downstream of the single-cycle RISCV core. Consumes the core's `PC_out` / `ALURes_out` debug outputs, arms on request, and starts recording one {PC, ALU result} entry per cycle when the PC matches a trigger address. It stops when the buffer fills and then drains the captured entries oldest-first over a valid/ready read port to the bench or a debug host.

## Interface
Parameters:
- `DEPTH`, 16, number of entries; must be a power of two and at least 2.
- `XLEN`, 32, PC and ALU result width.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low; `reset`=0 clears all state.
- `arm`  in  1  single-cycle request to clear the buffer and wait for the trigger.
- `trig_pc`  in  XLEN  trigger address, compared against `pc_in`.
- `pc_in`  in  XLEN  core `PC_out`.
- `alu_in`  in  XLEN  core `ALURes_out`.
- `rd_valid`  out  1  entry available on `rd_pc` / `rd_alu`.
- `rd_ready`  in  1  consumer accepts the entry.
- `rd_pc`  out  XLEN  PC of the oldest unread entry.
- `rd_alu`  out  XLEN  ALU result of the oldest unread entry.
- `state_o`  out  2  current FSM state encoding.
- `count_o`  out  $clog2(DEPTH)+1  number of entries stored.
- `full_o`  out  1  `count_o` == DEPTH.

## Operation
- The FSM has four states: IDLE=0, ARMED=1, CAPTURE=2, DONE=3.
- **IDLE:** inputs are ignored except `arm`. On `arm`=1, go to ARMED.
- **ARMED:** on a cycle where `pc_in`==`trig_pc`, write {`pc_in`,`alu_in`} at wr_ptr, set count to 1, and go to CAPTURE.
  - If DEPTH==1 the FSM would go straight to DONE; this is disallowed by the parameter rule.
- **CAPTURE:** write {`pc_in`,`alu_in`} every cycle. The write that makes count==DEPTH also moves the FSM to DONE. No trigger re-check is made.
- **DONE:** no writes.
  - `rd_valid`=1 while count>0.
  - Each cycle with `rd_valid`&&`rd_ready`: increment rd_ptr and decrement count.
  - The pop that takes count to 0 moves the FSM to IDLE.
- `arm`=1 in any state has priority over all other events:
  - wr_ptr, rd_ptr and count are cleared; next state is ARMED.
  - Any trigger match or pop in that same cycle is discarded.
  - In DONE, unread entries are dropped.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Since capture always starts from empty, wr_ptr never passes rd_ptr.
- `rd_valid` is low in IDLE, ARMED and CAPTURE. Reading during capture is not supported.
- `rd_pc` / `rd_alu` show the entry at rd_ptr when `rd_valid`=1 and are forced to 0 otherwise. Uninitialized storage never reaches the outputs.
- `rd_ready` is ignored while `rd_valid`=0.
- There is no equality masking; the comparison is a full XLEN-bit match.

## Timing
- Reset values: state IDLE (`state_o`=0), `count_o`=0, `full_o`=0, `rd_valid`=0, `rd_pc`=0, `rd_alu`=0, both pointers 0. Storage array is not reset.
- Reset is asserted asynchronously and released synchronously to `clk` by the surrounding design. Reset mid-capture or mid-drain aborts immediately to IDLE with count 0.
- Write latency: the entry sampled at rising edge N is visible in `count_o` after edge N.
- Trigger-to-first-entry latency is 0 cycles: the trigger cycle's own PC is entry 0.
- After `arm` at edge N, the earliest possible trigger is the cycle after edge N.
- DONE is entered on the edge that writes entry DEPTH-1. `rd_valid` rises combinationally from the registered state in the following cycle.
- Read port is a combinational data path from registered rd_ptr, count and state. Sustains one pop per cycle with `rd_ready` held high, so DEPTH pops take DEPTH cycles.
- `full_o` and `count_o` are combinational from the registered count.

## Structure
- Shared package `riscv_trace_pkg` contains:
  - `trace_state_t` enum (IDLE, ARMED, CAPTURE, DONE, 2-bit).
  - `trace_entry_t` packed struct {pc, alu}, XLEN each.
  - `TRACE_XLEN`=32 constant.
- One natural sub-module, `trace_ram`: a DEPTH x `trace_entry_t` array with a synchronous write port and a combinational read port, no reset.
- FSM, pointers and count live in the top level.

## Test plan
- **Reset:** hold `reset`=0 for 20 ns with `pc_in` toggling. Expect `state_o`=0, `count_o`=0, `rd_valid`=0, `rd_pc`=0.
- **Trigger and fill (DEPTH=4):** set `trig_pc`=0x10 and pulse `arm`; drive PCs 0x0C,0x10,0x14,0x18,0x1C,0x20 with `alu_in`=PC+1.
  - Expect DONE after 0x1C with `full_o`=1.
  - Draining yields (0x10,0x11),(0x14,0x15),(0x18,0x19),(0x1C,0x1D), then `state_o`=0.
- **No trigger:** arm with `trig_pc`=0xFFC and run 0x0..0x100. Expect the FSM to stay in ARMED with `count_o`=0.
- **Backpressure:** in DONE, toggle `rd_ready` 1,0,0,1,1,1. Expect exactly 4 pops in-order, with `rd_pc` held stable while `rd_ready`=0.
- **Re-arm priority:** `arm`=1 on the same edge as a pop in DONE with count=2. Expect ARMED, `count_o`=0, and `rd_valid`=0 next cycle.
- **Async reset mid-capture:** drop `reset` between clock edges at count=2. Expect immediate `state_o`=0 and `count_o`=0 before the next edge.
